cp0_exc_unit: RTL

//  Parametrised CP0 register file with a merged exception resolver for the 5-stage MIPS core.

---
 rtl/cp0_exc_unit.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit: CP0 registers with merged exception resolver; Count/Compare timer enabled by CP0_TIMER_INT_EN
module cp0_exc_unit #(
  parameter int          HW_INT_N   = 6,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter logic [31:0] PRID_VALUE = 32'h00004220,
  parameter int          COUNT_DIV  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we_i,
  input  logic [4:0]          waddr_i,
  input  logic [31:0]         wdata_i,
  input  logic [4:0]          raddr_i,
  output logic [31:0]         rdata_o,
  input  logic [HW_INT_N-1:0] int_i,
  input  logic                adel_i,
  input  logic                ades_i,
  input  logic                instadel_i,
  input  logic                syscall_i,
  input  logic                break_i,
  input  logic                eret_i,
  input  logic                invalid_i,
  input  logic                overflow_i,
  input  logic [31:0]         pc_i,
  input  logic                in_dslot_i,
  input  logic [31:0]         bad_addr_i,
  output logic [31:0]         excepttype_o,
  output logic [31:0]         newpc_o,
  output logic                flush_o,
  output logic [31:0]         status_o,
  output logic [31:0]         cause_o,
  output logic [31:0]         epc_o,
  output logic                timer_int_o
);
  logic [31:0]         badvaddr, count, compare, epc, epc_m, status_m, cause_m;
  logic [7:0]          im, im_m, ip;
  logic                exl, ie, bd, ti, exl_m, ie_m, int_req;
  logic [1:0]          ip_sw, ip_sw_m;
  logic [4:0]          exc_code, code;
  logic [HW_INT_N-1:0] ip_hw;
  logic [5:0]          hw6;
  logic                wr_status, wr_cause, wr_epc, wr_count, wr_compare;

  assign wr_status  = we_i && waddr_i == 5'd12;
  assign wr_cause   = we_i && waddr_i == 5'd13;
  assign wr_epc     = we_i && waddr_i == 5'd14;
  assign wr_count   = we_i && waddr_i == 5'd9;
  assign wr_compare = we_i && waddr_i == 5'd11;

  assign im_m    = wr_status ? wdata_i[15:8] : im;
  assign exl_m   = wr_status ? wdata_i[1] : exl;
  assign ie_m    = wr_status ? wdata_i[0] : ie;
  assign ip_sw_m = wr_cause ? wdata_i[9:8] : ip_sw;
  assign epc_m   = wr_epc ? wdata_i : epc;

  assign hw6      = 6'(ip_hw);
  assign ip       = {hw6[5] | ti, hw6[4:0], ip_sw_m};
  assign status_o = {9'd0, 1'b1, 6'd0, im, 6'd0, exl, ie};
  assign status_m = {9'd0, 1'b1, 6'd0, im_m, 6'd0, exl_m, ie_m};
  assign cause_o  = {bd, ti, 14'd0, hw6[5] | ti, hw6[4:0], ip_sw, 1'b0, exc_code, 2'b00};
  assign cause_m  = {bd, ti, 14'd0, ip, 1'b0, exc_code, 2'b00};
  assign epc_o    = epc;
  assign timer_int_o = ti;

  assign int_req = |(ip & im_m) && !exl_m && ie_m;
  assign code = rst                       ? 5'd0  :
                int_req                   ? 5'd1  :
                (instadel_i || adel_i)    ? 5'd4  :
                ades_i                    ? 5'd5  :
                syscall_i                 ? 5'd8  :
                break_i                   ? 5'd9  :
                eret_i                    ? 5'd14 :
                invalid_i                 ? 5'd10 :
                overflow_i                ? 5'd12 : 5'd0;
  assign excepttype_o = {27'd0, code};
  assign flush_o      = code != 5'd0;
  assign newpc_o      = !flush_o ? 32'd0 : code == 5'd14 ? epc_m : EXC_VECTOR;

  always_comb begin
    rdata_o = 32'd0;
    case (raddr_i)
      5'd8:    rdata_o = badvaddr;
      5'd9:    rdata_o = count;
      5'd11:   rdata_o = compare;
      5'd12:   rdata_o = status_m;
      5'd13:   rdata_o = cause_m;
      5'd14:   rdata_o = epc_m;
      5'd15:   rdata_o = PRID_VALUE;
      default: rdata_o = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      badvaddr <= 32'd0;
      epc      <= 32'd0;
      im       <= 8'd0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip_sw    <= 2'd0;
      exc_code <= 5'd0;
      ip_hw    <= '0;
    end else begin
      ip_hw <= int_i;
      if (wr_status) begin
        im  <= wdata_i[15:8];
        exl <= wdata_i[1];
        ie  <= wdata_i[0];
      end
      if (wr_cause) ip_sw <= wdata_i[9:8];
      if (wr_epc) epc <= wdata_i;
      if (flush_o) begin
        if (code == 5'd14) exl <= 1'b0;
        else begin
          exl      <= 1'b1;
          exc_code <= code == 5'd1 ? 5'd0 : code;
          epc      <= exl_m ? epc : in_dslot_i ? pc_i - 32'd4 : pc_i;
          if (!exl_m) bd <= in_dslot_i;
          if (code == 5'd4 || code == 5'd5) badvaddr <= (code == 5'd4 && instadel_i) ? pc_i : bad_addr_i;
        end
      end
    end
  end

`ifdef CP0_TIMER_INT_EN
  logic [3:0] div_cnt;
  logic       div_wrap;
  assign div_wrap = div_cnt == 4'(COUNT_DIV - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= 32'd0;
      compare <= 32'd0;
      div_cnt <= 4'd0;
      ti      <= 1'b0;
    end else begin
      count   <= wr_count ? wdata_i : div_wrap ? count + 32'd1 : count;
      div_cnt <= (wr_count || div_wrap) ? 4'd0 : div_cnt + 4'd1;
      ti      <= wr_compare ? 1'b0 : (!wr_count && div_wrap && count + 32'd1 == compare) ? 1'b1 : ti;
      if (wr_compare) compare <= wdata_i;
    end
  end
`else
  assign ti = 1'b0;
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= 32'd0;
      compare <= 32'd0;
    end else begin
      if (wr_count) count <= wdata_i;
      if (wr_compare) compare <= wdata_i;
    end
  end
`endif
endmodule
